ch2_4sipo_rx: RTL

Serial-to-parallel receiver that sits directly downstream of the 4-bit parallel-in/serial-out shift register. It consumes that stage's serial output Q and the same SH_LDN strobe, and reassembles each shifted word. It presents each word on a parallel bus with a valid/acknowledge handshake. It flags truncated frames and words lost to a consumer that has not acknowledged.

---
 rtl/ch2_4sipo_rx.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ch2_4sipo_rx.sv
// Serial-to-parallel receiver for the upstream PISO stream. It reassembles each
// frame started by SH_LDN=0 and hands the word out on a valid/acknowledge pair.
module ch2_4sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             SH_LDN,
  input  logic             SIN,
  input  logic             DACK,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  output logic             BUSY,
  output logic             FRAME_ERR,
  output logic             OVERRUN
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CNT_ZERO + 1'b1;
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               dvalid_q, dvalid_d;
  logic               busy_q, busy_d;
  logic               ferr_q, ferr_d;
  logic               ovr_q, ovr_d;
  logic [WIDTH-1:0]   shifted_s;
  logic               frame_done_s;

  // State register and all output/datapath flops.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= CNT_ZERO;
      sr_q     <= {WIDTH{1'b0}};
      dout_q   <= {WIDTH{1'b0}};
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state logic: frame start, bit assembly and completion detection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    frame_done_s = 1'b0;
    ferr_d       = 1'b0;
    if (MSB_FIRST) begin
      shifted_s = {sr_q[WIDTH-2:0], SIN};
    end else begin
      shifted_s = {SIN, sr_q[WIDTH-1:1]};
    end
    if (!SH_LDN) begin
      // A load strobe always restarts; only a partially filled frame is an error.
      ferr_d  = (state_q == ST_SHIFT) && (cnt_q != CNT_ZERO) && (cnt_q < CNT_FULL);
      state_d = ST_SHIFT;
      cnt_d   = CNT_ZERO;
      sr_d    = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          sr_d  = shifted_s;
          cnt_d = cnt_q + CNT_ONE;
          if ((cnt_q + CNT_ONE) == CNT_FULL) begin
            frame_done_s = 1'b1;
            state_d      = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          sr_d    = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Output stage: hand-off to the consumer, overrun capture and busy flag.
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_d    = ovr_q;
    busy_d   = (state_d == ST_SHIFT);
    if (frame_done_s) begin
      if (!dvalid_q || DACK) begin
        dout_d   = sr_d;
        dvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (DACK && dvalid_q) begin
      dvalid_d = 1'b0;
    end else begin
      dvalid_d = dvalid_q;
    end
  end

  assign DOUT      = dout_q;
  assign DVALID    = dvalid_q;
  assign BUSY      = busy_q;
  assign FRAME_ERR = ferr_q;
  assign OVERRUN   = ovr_q;

endmodule
